// File: rtl/keypad_bcd_encoder.sv
// Debounced decimal keypad to three shift-entry BCD timer digits (m:ss) plus key strobes.
// Optional feature: define KEYPAD_SYNC_EN to add a 2-flop input synchronizer (+2 cycles latency).
module keypad_bcd_encoder #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] keypad,
    input  logic       enable,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min,
    output logic       key_strobe,
    output logic [3:0] key_code,
    output logic       key_reject,
    output logic       nonzero
);

    localparam logic [7:0] C_DB = 8'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_DB,
        S_HELD,
        S_REL_DB
    } state_t;

    logic [9:0] w_keys;

`ifdef KEYPAD_SYNC_EN
    logic [9:0] r_sync1;
    logic [9:0] r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= keypad;
            r_sync2 <= r_sync1;
        end
    end

    assign w_keys = r_sync2;
`else
    assign w_keys = keypad;
`endif

    logic       w_zero;
    logic       w_valid;
    logic [3:0] w_code;

    assign w_zero  = (w_keys == 10'd0);
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign w_valid = !w_zero && ((w_keys & (w_keys - 10'd1)) == 10'd0);

    always_comb begin
        w_code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (w_keys[i]) begin
                w_code = 4'(i);
            end
        end
    end

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic [3:0] r_cand;
    logic [3:0] w_cand_next;
    logic       w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_cand  <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_cand  <= w_cand_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cand_next  = r_cand;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    w_cand_next = w_code;
                    if (C_DB <= 8'd1) begin
                        w_state_next = S_HELD;
                        w_cnt_next   = 8'd0;
                        w_accept     = 1'b1;
                    end else begin
                        w_state_next = S_PRESS_DB;
                        w_cnt_next   = 8'd1;
                    end
                end
            end
            S_PRESS_DB: begin
                if (w_valid && (w_code == r_cand)) begin
                    if (r_cnt + 8'd1 >= C_DB) begin
                        w_state_next = S_HELD;
                        w_cnt_next   = 8'd0;
                        w_accept     = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end else begin
                    // A differing pattern only aborts; it is not taken as a new candidate.
                    w_state_next = S_IDLE;
                    w_cnt_next   = 8'd0;
                end
            end
            S_HELD: begin
                if (w_zero) begin
                    if (C_DB <= 8'd1) begin
                        w_state_next = S_IDLE;
                        w_cnt_next   = 8'd0;
                    end else begin
                        w_state_next = S_REL_DB;
                        w_cnt_next   = 8'd1;
                    end
                end
            end
            S_REL_DB: begin
                if (w_zero) begin
                    if (r_cnt + 8'd1 >= C_DB) begin
                        w_state_next = S_IDLE;
                        w_cnt_next   = 8'd0;
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end else begin
                    w_state_next = S_HELD;
                    w_cnt_next   = 8'd0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    logic [3:0] r_ones;
    logic [3:0] r_tens;
    logic [3:0] r_min;
    logic [3:0] r_code;
    logic       r_strobe;
    logic       r_reject;
    logic       w_shift_ok;

    // Shifting a digit above 5 into the tens place would make an invalid seconds value.
    assign w_shift_ok = enable && (r_ones <= 4'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ones   <= 4'd0;
            r_tens   <= 4'd0;
            r_min    <= 4'd0;
            r_code   <= 4'd0;
            r_strobe <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            r_strobe <= w_accept;
            r_reject <= w_accept && (clear || !w_shift_ok);
            if (w_accept) begin
                r_code <= w_cand_next;
            end
            if (clear) begin
                r_ones <= 4'd0;
                r_tens <= 4'd0;
                r_min  <= 4'd0;
            end else if (w_accept && w_shift_ok) begin
                r_min  <= r_tens;
                r_tens <= r_ones;
                r_ones <= w_cand_next;
            end
        end
    end

    assign sec_ones   = r_ones;
    assign sec_tens   = r_tens;
    assign min        = r_min;
    assign key_code   = r_code;
    assign key_strobe = r_strobe;
    assign key_reject = r_reject;
    assign nonzero    = (r_ones != 4'd0) || (r_tens != 4'd0) || (r_min != 4'd0);

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Bench for keypad_bcd_encoder: press table, hand-written corner sequences, and
// randomized press/release segments checked against a press-level reference model.
module tb_keypad_bcd_encoder;

    localparam int D = 4;
`ifdef KEYPAD_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] keypad = '0;
    logic       enable = 1'b1;
    logic       clear = 1'b0;
    logic [3:0] sec_ones, sec_tens, min, key_code;
    logic       key_strobe, key_reject, nonzero;

    keypad_bcd_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .keypad     (keypad),
        .enable     (enable),
        .clear      (clear),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min        (min),
        .key_strobe (key_strobe),
        .key_code   (key_code),
        .key_reject (key_reject),
        .nonzero    (nonzero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;
    int n_str = 0;
    int n_rej = 0;
    int last_str_edge = -1;

    typedef struct {
        logic [9:0] pat;
        int         hold;
        logic       en;
        int         exp_str;
        int         exp_rej;
        int         exp_code;
        int         m;
        int         t;
        int         o;
    } vec_t;

    vec_t vecs[8];

    // Reference model state for the randomized phase.
    int m_min, m_tens, m_ones, m_code;
    int acc_edge[$];
    int acc_code[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_digits(input string tag, input int m, input int t, input int o);
        check({tag, " min"}, 32'(min), 32'(m));
        check({tag, " sec_tens"}, 32'(sec_tens), 32'(t));
        check({tag, " sec_ones"}, 32'(sec_ones), 32'(o));
        check({tag, " nonzero"}, 32'(nonzero), 32'((m != 0) || (t != 0) || (o != 0)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_no++;
        if (key_strobe === 1'b1) begin
            n_str++;
            last_str_edge = edge_no;
        end
        if (key_reject === 1'b1) n_rej++;
    endtask

    task automatic press(input logic [9:0] pat, input int hold);
        keypad = pat;
        repeat (hold) step();
        keypad = '0;
        repeat (6) step();
    endtask

    // One randomized cycle: drive, clock, advance the model, compare every output.
    task automatic rand_cycle(input logic [9:0] pat, input bit sched, input int code);
        bit acc;
        int ec;
        keypad = pat;
        enable = (($urandom % 6) != 0);
        clear  = (($urandom % 16) == 0);
        if (sched) begin
            acc_edge.push_back(edge_no + 1 + LAT);
            acc_code.push_back(code);
        end
        step();
        acc = 1'b0;
        ec  = 0;
        if (acc_edge.size() > 0 && acc_edge[0] == edge_no) begin
            acc = 1'b1;
            ec  = acc_code[0];
            void'(acc_edge.pop_front());
            void'(acc_code.pop_front());
        end
        check("rand key_strobe", 32'(key_strobe), 32'(acc));
        check("rand key_reject", 32'(key_reject), 32'(acc && (clear || !enable || m_ones > 5)));
        if (acc) m_code = ec;
        if (clear) begin
            m_min = 0; m_tens = 0; m_ones = 0;
        end else if (acc && enable && m_ones <= 5) begin
            m_min = m_tens; m_tens = m_ones; m_ones = ec;
        end
        check("rand key_code", 32'(key_code), 32'(m_code));
        check_digits("rand", m_min, m_tens, m_ones);
    endtask

    initial begin
        vecs[0] = '{10'b0000000010, 6, 1'b1, 1, 0, 1, 0, 0, 1};
        vecs[1] = '{10'b0000001000, 6, 1'b1, 1, 0, 3, 0, 1, 3};
        vecs[2] = '{10'b0000000001, 6, 1'b1, 1, 0, 0, 1, 3, 0};
        vecs[3] = '{10'b0010000000, 6, 1'b1, 1, 0, 7, 3, 0, 7};
        vecs[4] = '{10'b0000000100, 6, 1'b1, 1, 1, 2, 3, 0, 7};
        vecs[5] = '{10'b0000001001, 10, 1'b1, 0, 0, 2, 3, 0, 7};
        vecs[6] = '{10'b0000010000, 6, 1'b0, 1, 1, 4, 3, 0, 7};
        vecs[7] = '{10'b0000000000, 3, 1'b1, 0, 0, 4, 3, 0, 7};

        // Reset state
        #12;
        check("reset key_strobe", 32'(key_strobe), 0);
        check("reset key_reject", 32'(key_reject), 0);
        check("reset key_code", 32'(key_code), 0);
        check_digits("reset", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            n_str = 0;
            n_rej = 0;
            enable = vecs[i].en;
            press(vecs[i].pat, vecs[i].hold);
            enable = 1'b1;
            check($sformatf("vec%0d strobes", i), 32'(n_str), 32'(vecs[i].exp_str));
            check($sformatf("vec%0d rejects", i), 32'(n_rej), 32'(vecs[i].exp_rej));
            check($sformatf("vec%0d key_code", i), 32'(key_code), 32'(vecs[i].exp_code));
            check_digits($sformatf("vec%0d", i), vecs[i].m, vecs[i].t, vecs[i].o);
            $display("vec %0d pat=%b hold=%0d strobes=%0d rejects=%0d digits=%0d:%0d%0d",
                     i, vecs[i].pat, vecs[i].hold, n_str, n_rej, min, sec_tens, sec_ones);
        end

        // Bounce on key 5 never completes a debounce
        n_str = 0;
        keypad = 10'b0000100000; repeat (2) step();
        keypad = '0;             repeat (1) step();
        keypad = 10'b0000100000; repeat (3) step();
        keypad = '0;             repeat (6) step();
        check("bounce strobes", 32'(n_str), 0);
        check_digits("bounce", 3, 0, 7);
        $display("bounce key5 strobes=%0d", n_str);

        // Key 5 held 20 cycles: one strobe on the D-th stable edge (rejected, ones=7)
        n_str = 0; n_rej = 0; edge_no = 0; last_str_edge = -1;
        press(10'b0000100000, 20);
        check("hold20 strobes", 32'(n_str), 1);
        check("hold20 strobe edge", 32'(last_str_edge), 32'(D + LAT));
        check("hold20 rejects", 32'(n_rej), 1);
        check("hold20 key_code", 32'(key_code), 5);
        $display("hold key5 strobes=%0d at edge %0d", n_str, last_str_edge);

        // Invalid multi-key pattern, then drop to single key 3 without a release
        n_str = 0; n_rej = 0;
        keypad = 10'b0000001001; repeat (10) step();
        check("multi strobes", 32'(n_str), 0);
        keypad = 10'b0000001000; repeat (4) step();
        keypad = '0;             repeat (6) step();
        check("drop strobes", 32'(n_str), 1);
        check("drop key_code", 32'(key_code), 3);
        $display("multi->key3 strobes=%0d code=%0d", n_str, key_code);

        // Plain clear, then clear coincident with an accept that would otherwise shift
        clear = 1'b1; step(); clear = 1'b0;
        check_digits("clear", 0, 0, 0);
        check("clear key_code", 32'(key_code), 3);
        press(10'b0000100000, 6);
        check_digits("press5", 0, 0, 5);
        n_str = 0; n_rej = 0;
        keypad = 10'b0100000000;
        for (int i = 1; i <= D + LAT; i++) begin
            if (i == D + LAT) clear = 1'b1;
            step();
        end
        clear = 1'b0;
        check("clracc key_strobe", 32'(key_strobe), 1);
        check("clracc key_reject", 32'(key_reject), 1);
        check("clracc key_code", 32'(key_code), 8);
        check("clracc strobes", 32'(n_str), 1);
        check_digits("clracc", 0, 0, 0);
        keypad = '0; repeat (6) step();
        $display("clear+accept8 digits=%0d:%0d%0d", min, sec_tens, sec_ones);
        press(10'b0000000010, 6);
        check_digits("press1", 0, 0, 1);

        // Reset in the middle of debouncing key 9, key kept held
        keypad = 10'b1000000000;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("midrst key_strobe", 32'(key_strobe), 0);
        check("midrst key_reject", 32'(key_reject), 0);
        check("midrst key_code", 32'(key_code), 0);
        check_digits("midrst", 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        edge_no = 0; n_str = 0; last_str_edge = -1;
        repeat (20) step();
        check("postrst strobes", 32'(n_str), 1);
        check("postrst strobe edge", 32'(last_str_edge), 32'(D + LAT));
        check("postrst key_code", 32'(key_code), 9);
        check_digits("postrst", 0, 0, 9);
        keypad = '0; repeat (8) step();
        $display("reset mid-debounce strobes=%0d at edge %0d", n_str, last_str_edge);

        // Randomized press segments from a fresh reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        edge_no = 0;
        m_min = 0; m_tens = 0; m_ones = 0; m_code = 0;
        for (int p = 0; p < 60; p++) begin
            logic [9:0] pat;
            bit         valid;
            int         k, k2, len, gap;
            len = $urandom_range(1, 8);
            gap = $urandom_range(D, 8);
            k = $urandom_range(0, 9);
            pat = 10'd1 << k;
            valid = 1'b1;
            if (($urandom % 8) == 0) begin
                k2 = (k + $urandom_range(1, 9)) % 10;
                pat = pat | (10'd1 << k2);
                valid = 1'b0;
            end
            for (int c = 0; c < len; c++) rand_cycle(pat, valid && (c == D - 1), k);
            for (int c = 0; c < gap; c++) rand_cycle('0, 1'b0, 0);
            $display("rand %0d pat=%b len=%0d gap=%0d digits=%0d:%0d%0d",
                     p, pat, len, gap, m_min, m_tens, m_ones);
        end
        check("rand queue drained", 32'(acc_edge.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
